fft_8: RTL and testbench



---
 rtl/fft_8_pkg.sv | 39 +++
 rtl/fft_8_bfly.sv | 63 ++++++
 rtl/fft_8.sv | 145 ++++++++++++++
 tb/tb_fft_8.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_8_pkg.sv
// Shared widths, twiddle constants and sign-magnitude conversion helpers
// for the 8-point real-input DFT.
package fft_8_pkg;

  localparam int SAMPLE_W  = 32;
  localparam int FRAC_W    = 16;
  localparam int INT_W     = 36;
  localparam int TWIDDLE_C = 46341;
  localparam int ACC_W     = INT_W + FRAC_W;

  localparam logic [SAMPLE_W-2:0] MAG_MAX = '1;

  localparam logic [1:0] TW_W0 = 2'd0;
  localparam logic [1:0] TW_W1 = 2'd1;
  localparam logic [1:0] TW_W2 = 2'd2;
  localparam logic [1:0] TW_W3 = 2'd3;

  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic logic signed [SAMPLE_W-1:0] sm_to_tc(input logic [SAMPLE_W-1:0] s);
    logic signed [SAMPLE_W-1:0] mag;
    mag = {1'b0, s[SAMPLE_W-2:0]};
    return s[SAMPLE_W-1] ? -mag : mag;
  endfunction

  // Round half away from zero on the magnitude, clamp, and never emit -0.
  function automatic logic [SAMPLE_W-1:0] tc_to_sm_sat(input acc_t v);
    logic [ACC_W-1:0]    u;
    logic [ACC_W-1:0]    mag;
    logic [ACC_W-1:0]    ip;
    logic [SAMPLE_W-2:0] m;
    u   = v;
    mag = u[ACC_W-1] ? (~u + ACC_W'(1)) : u;
    ip  = (mag + ACC_W'(1 << (FRAC_W-1))) >> FRAC_W;
    m   = (ip > ACC_W'(MAG_MAX)) ? MAG_MAX : ip[SAMPLE_W-2:0];
    return {u[ACC_W-1] && (m != '0), m};
  endfunction

endpackage

// File: rtl/fft_8_bfly.sv
// Complex radix-2 butterfly: y0 = a + W*b, y1 = a - W*b, with W selected
// from {1, c-jc, -j, -c-jc}.
module fft_8_bfly
  import fft_8_pkg::*;
(
  input  logic [1:0]              tw,
  input  logic signed [ACC_W-1:0] ar,
  input  logic signed [ACC_W-1:0] ai,
  input  logic signed [ACC_W-1:0] br,
  input  logic signed [ACC_W-1:0] bi,
  output logic signed [ACC_W-1:0] y0r,
  output logic signed [ACC_W-1:0] y0i,
  output logic signed [ACC_W-1:0] y1r,
  output logic signed [ACC_W-1:0] y1i
);

  logic signed [ACC_W-1:0] tr;
  logic signed [ACC_W-1:0] ti;

  // Truncation toward zero keeps mul_c(-x) == -mul_c(x), which is what makes
  // the upper bins exact conjugates of the lower ones.
  function automatic logic signed [ACC_W-1:0] mul_c(input logic signed [ACC_W-1:0] x);
    logic [ACC_W-1:0]        ux;
    logic [ACC_W-1:0]        mag;
    logic [ACC_W+FRAC_W-1:0] prod;
    logic signed [ACC_W-1:0] t;
    ux   = x;
    mag  = ux[ACC_W-1] ? (~ux + ACC_W'(1)) : ux;
    prod = (ACC_W+FRAC_W)'(mag) * (ACC_W+FRAC_W)'(TWIDDLE_C);
    prod = prod >> FRAC_W;
    t    = $signed(prod[ACC_W-1:0]);
    return ux[ACC_W-1] ? -t : t;
  endfunction

  always_comb begin
    tr = br;
    ti = bi;
    case (tw)
      TW_W1: begin
        tr = mul_c(br + bi);
        ti = mul_c(bi - br);
      end
      TW_W2: begin
        tr = bi;
        ti = -br;
      end
      TW_W3: begin
        tr = mul_c(bi - br);
        ti = -mul_c(br + bi);
      end
      default: begin
        tr = br;
        ti = bi;
      end
    endcase
  end

  assign y0r = ar + tr;
  assign y0i = ai + ti;
  assign y1r = ar - tr;
  assign y1i = ai - ti;

endmodule

// File: rtl/fft_8.sv
// Fully parallel 8-point radix-2 DIT DFT of real sign-magnitude samples,
// one vector per clock, result registered one cycle later.
module fft_8
  import fft_8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] A0,
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  input  logic [31:0] A3,
  input  logic [31:0] A4,
  input  logic [31:0] A5,
  input  logic [31:0] A6,
  input  logic [31:0] A7,
  output logic [31:0] Xr0,
  output logic [31:0] Xr1,
  output logic [31:0] Xr2,
  output logic [31:0] Xr3,
  output logic [31:0] Xr4,
  output logic [31:0] Xr5,
  output logic [31:0] Xr6,
  output logic [31:0] Xr7,
  output logic [31:0] Xi0,
  output logic [31:0] Xi1,
  output logic [31:0] Xi2,
  output logic [31:0] Xi3,
  output logic [31:0] Xi4,
  output logic [31:0] Xi5,
  output logic [31:0] Xi6,
  output logic [31:0] Xi7,
  output logic        valid_out
);

  logic [SAMPLE_W-1:0] a_sm [8];
  acc_t                x_re_p0 [8];
  acc_t                x_im_p0 [8];
  acc_t                s1_re_p0 [8];
  acc_t                s1_im_p0 [8];
  acc_t                s2_re_p0 [8];
  acc_t                s2_im_p0 [8];
  acc_t                s3_re_p0 [8];
  acc_t                s3_im_p0 [8];
  logic [SAMPLE_W-1:0] xr_p1 [8];
  logic [SAMPLE_W-1:0] xi_p1 [8];
  logic                vld_p1;

  function automatic acc_t to_acc(input logic [SAMPLE_W-1:0] s);
    logic signed [SAMPLE_W-1:0] t;
    t = sm_to_tc(s);
    return {{(INT_W-SAMPLE_W){t[SAMPLE_W-1]}}, t, {FRAC_W{1'b0}}};
  endfunction

  assign a_sm[0] = A0;
  assign a_sm[1] = A1;
  assign a_sm[2] = A2;
  assign a_sm[3] = A3;
  assign a_sm[4] = A4;
  assign a_sm[5] = A5;
  assign a_sm[6] = A6;
  assign a_sm[7] = A7;

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      x_re_p0[n] = to_acc(a_sm[n]);
      x_im_p0[n] = '0;
    end
  end

  // Stage 1: bit-reversed pairs (n, n+4), unit twiddle
  for (genvar g = 0; g < 4; g++) begin : g_st1
    localparam int IA = ((g & 1) << 1) | (g >> 1);
    fft_8_bfly u_bfly (
      .tw (TW_W0),
      .ar (x_re_p0[IA]),     .ai (x_im_p0[IA]),
      .br (x_re_p0[IA+4]),   .bi (x_im_p0[IA+4]),
      .y0r(s1_re_p0[2*g]),   .y0i(s1_im_p0[2*g]),
      .y1r(s1_re_p0[2*g+1]), .y1i(s1_im_p0[2*g+1])
    );
  end

  // Stage 2: two 4-point combines, twiddles W0 and W2
  for (genvar g = 0; g < 4; g++) begin : g_st2
    localparam int IA = (g >> 1) * 4 + (g & 1);
    localparam logic [1:0] TW = (g & 1) ? TW_W2 : TW_W0;
    fft_8_bfly u_bfly (
      .tw (TW),
      .ar (s1_re_p0[IA]),   .ai (s1_im_p0[IA]),
      .br (s1_re_p0[IA+2]), .bi (s1_im_p0[IA+2]),
      .y0r(s2_re_p0[IA]),   .y0i(s2_im_p0[IA]),
      .y1r(s2_re_p0[IA+2]), .y1i(s2_im_p0[IA+2])
    );
  end

  // Stage 3: even/odd halves combined into bins k and k+4
  for (genvar g = 0; g < 4; g++) begin : g_st3
    localparam logic [1:0] TW = 2'(g);
    fft_8_bfly u_bfly (
      .tw (TW),
      .ar (s2_re_p0[g]),   .ai (s2_im_p0[g]),
      .br (s2_re_p0[g+4]), .bi (s2_im_p0[g+4]),
      .y0r(s3_re_p0[g]),   .y0i(s3_im_p0[g]),
      .y1r(s3_re_p0[g+4]), .y1i(s3_im_p0[g+4])
    );
  end

  // Output register: rounding, saturation and sign-magnitude conversion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        xr_p1[k] <= '0;
        xi_p1[k] <= '0;
      end
    end else begin
      vld_p1 <= valid_in;
      if (valid_in) begin
        for (int k = 0; k < 8; k++) begin
          xr_p1[k] <= tc_to_sm_sat(s3_re_p0[k]);
          xi_p1[k] <= tc_to_sm_sat(s3_im_p0[k]);
        end
      end
    end
  end

  assign Xr0 = xr_p1[0];
  assign Xr1 = xr_p1[1];
  assign Xr2 = xr_p1[2];
  assign Xr3 = xr_p1[3];
  assign Xr4 = xr_p1[4];
  assign Xr5 = xr_p1[5];
  assign Xr6 = xr_p1[6];
  assign Xr7 = xr_p1[7];
  assign Xi0 = xi_p1[0];
  assign Xi1 = xi_p1[1];
  assign Xi2 = xi_p1[2];
  assign Xi3 = xi_p1[3];
  assign Xi4 = xi_p1[4];
  assign Xi5 = xi_p1[5];
  assign Xi6 = xi_p1[6];
  assign Xi7 = xi_p1[7];
  assign valid_out = vld_p1;

endmodule

// File: tb/tb_fft_8.sv
// Scoreboard bench for fft_8: directed vectors plus random vectors checked
// against a direct-summation DFT model.
module tb_fft_8;

  typedef logic [7:0][31:0] vec_t;
  typedef struct packed {
    vec_t xr;
    vec_t xi;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] A0, A1, A2, A3, A4, A5, A6, A7;
  logic [31:0] Xr0, Xr1, Xr2, Xr3, Xr4, Xr5, Xr6, Xr7;
  logic [31:0] Xi0, Xi1, Xi2, Xi3, Xi4, Xi5, Xi6, Xi7;
  logic        valid_out;

  res_t exp_q[$];
  res_t last = '0;
  logic exp_vld = 1'b0;
  int   checks = 0;
  int   passes = 0;

  fft_8 dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7),
    .Xr0(Xr0), .Xr1(Xr1), .Xr2(Xr2), .Xr3(Xr3), .Xr4(Xr4), .Xr5(Xr5), .Xr6(Xr6), .Xr7(Xr7),
    .Xi0(Xi0), .Xi1(Xi1), .Xi2(Xi2), .Xi3(Xi3), .Xi4(Xi4), .Xi5(Xi5), .Xi6(Xi6), .Xi7(Xi7),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // valid_out must follow valid_in by one edge; reset forces it low at once
  always @(posedge clk or posedge rst) begin
    if (rst) exp_vld <= 1'b0;
    else     exp_vld <= valid_in;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s got=%h required=%h at %0t", name, got, want, $time);
  endtask

  // Reference: X_k = sum_n A_n * e^{-j2pi kn/8}, twiddles scaled by 65536
  function automatic longint cosq(input int m);
    case (m % 8)
      0: return 65536;
      1: return 46341;
      2: return 0;
      3: return -46341;
      4: return -65536;
      5: return -46341;
      6: return 0;
      default: return 46341;
    endcase
  endfunction

  function automatic longint sinq(input int m);
    case (m % 8)
      0: return 0;
      1: return -46341;
      2: return -65536;
      3: return -46341;
      4: return 0;
      5: return 46341;
      6: return 65536;
      default: return 46341;
    endcase
  endfunction

  function automatic logic [31:0] round_sm(input longint v);
    longint mag;
    longint ip;
    mag = (v < 0) ? -v : v;
    ip  = (mag + 32768) / 65536;
    if (ip > 64'sd2147483647) ip = 64'sd2147483647;
    return {(v < 0) && (ip != 0), ip[30:0]};
  endfunction

  function automatic res_t model(input vec_t a);
    res_t   r;
    longint x;
    longint re;
    longint im;
    for (int k = 0; k < 8; k++) begin
      re = 0;
      im = 0;
      for (int n = 0; n < 8; n++) begin
        x = longint'(a[n][30:0]);
        if (a[n][31]) x = -x;
        re += x * cosq(k * n);
        im += x * sinq(k * n);
      end
      r.xr[k] = round_sm(re);
      r.xi[k] = round_sm(im);
    end
    return r;
  endfunction

  function automatic logic [31:0] sm(input int v);
    return (v < 0) ? {1'b1, 31'(-v)} : {1'b0, 31'(v)};
  endfunction

  function automatic vec_t mk(input int t[8]);
    vec_t r;
    for (int n = 0; n < 8; n++) r[n] = sm(t[n]);
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 5))
        0:       r[n] = {$urandom_range(0, 1) == 1, 31'($urandom_range(0, 1000))};
        1:       r[n] = 32'h8000_0000;
        2:       r[n] = {$urandom_range(0, 1) == 1, 31'h7FFF_FFFF};
        default: r[n] = $urandom;
      endcase
    end
    return r;
  endfunction

  task automatic drive(input vec_t v);
    {A7, A6, A5, A4, A3, A2, A1, A0} = v;
  endtask

  task automatic send(input vec_t v, input res_t e);
    drive(v);
    valid_in = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      drive(rand_vec());
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pop on valid_out, otherwise outputs must hold the last result
  always @(negedge clk) begin
    vec_t gr;
    vec_t gi;
    gr = {Xr7, Xr6, Xr5, Xr4, Xr3, Xr2, Xr1, Xr0};
    gi = {Xi7, Xi6, Xi5, Xi4, Xi3, Xi2, Xi1, Xi0};
    chk("valid_out", {31'd0, valid_out}, {31'd0, exp_vld});
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result valid_out=1 required no result at %0t", $time);
      end else begin
        last = exp_q.pop_front();
      end
    end
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("Xr%0d", k), gr[k], last.xr[k]);
      chk($sformatf("Xi%0d", k), gi[k], last.xi[k]);
    end
  end

  initial begin
    int   ta[8];
    int   tr[8];
    int   ti[8];
    vec_t v;
    res_t e;
    drive('0);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Mixed vector
    ta = '{240, 260, 0, 220, 0, 300, 400, 0};
    tr = '{1420, 56, -160, 424, -140, 424, -160, 56};
    ti = '{0, 273, -340, -527, 0, 527, 340, -273};
    e.xr = mk(tr); e.xi = mk(ti);
    send(mk(ta), e);

    // Impulse
    ta = '{1000, 0, 0, 0, 0, 0, 0, 0};
    tr = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    ti = '{0, 0, 0, 0, 0, 0, 0, 0};
    e.xr = mk(tr); e.xi = mk(ti);
    send(mk(ta), e);

    // DC
    ta = '{100, 100, 100, 100, 100, 100, 100, 100};
    tr = '{800, 0, 0, 0, 0, 0, 0, 0};
    e.xr = mk(tr); e.xi = mk(ti);
    send(mk(ta), e);

    // Single negative sample
    ta = '{0, -100, 0, 0, 0, 0, 0, 0};
    tr = '{-100, -71, 0, 71, 100, 71, 0, -71};
    ti = '{0, 71, 100, 71, 0, -71, -100, -71};
    e.xr = mk(tr); e.xi = mk(ti);
    send(mk(ta), e);

    // Saturation
    for (int n = 0; n < 8; n++) v[n] = 32'h7FFF_FFFF;
    e = '0;
    e.xr[0] = 32'h7FFF_FFFF;
    send(v, e);

    idle(3);

    repeat (60) begin
      v = rand_vec();
      send(v, model(v));
      if ($urandom_range(0, 4) == 0) idle(1);
    end

    // Reset asserted between edges with a vector in flight
    ta = '{240, 260, 0, 220, 0, 300, 400, 0};
    send(mk(ta), model(mk(ta)));
    drive(rand_vec());
    valid_in = 1'b1;
    #2;
    rst = 1'b1;
    exp_q.delete();
    last = '0;
    #1;
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_Xr0", Xr0, 32'd0);
    chk("rst_Xr1", Xr1, 32'd0);
    chk("rst_Xi1", Xi1, 32'd0);
    chk("rst_Xi7", Xi7, 32'd0);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    tr = '{1420, 56, -160, 424, -140, 424, -160, 56};
    ti = '{0, 273, -340, -527, 0, 527, 340, -273};
    e.xr = mk(tr); e.xi = mk(ti);
    send(mk(ta), e);
    idle(3);

    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL queue_drain pending=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
